// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : y86_pkg                                                          |
// | Purpose : Shared Y86-64 constants: register IDs, icodes and status codes.  |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package y86_pkg;

   // Register IDs
   localparam logic [3:0] RRAX  = 4'h0;
   localparam logic [3:0] RRCX  = 4'h1;
   localparam logic [3:0] RRDX  = 4'h2;
   localparam logic [3:0] RRBX  = 4'h3;
   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RRBP  = 4'h5;
   localparam logic [3:0] RRSI  = 4'h6;
   localparam logic [3:0] RRDI  = 4'h7;
   localparam logic [3:0] R8    = 4'h8;
   localparam logic [3:0] R9    = 4'h9;
   localparam logic [3:0] R10   = 4'hA;
   localparam logic [3:0] R11   = 4'hB;
   localparam logic [3:0] R12   = 4'hC;
   localparam logic [3:0] R13   = 4'hD;
   localparam logic [3:0] R14   = 4'hE;
   localparam logic [3:0] RNONE = 4'hF;

   localparam int NUM_REGS = 15;

   // Instruction codes
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Processor status
   typedef enum logic [2:0] {
      SAOK = 3'd1,
      SHLT = 3'd2,
      SADR = 3'd3,
      SINS = 3'd4
   } stat_t;

   // True when the ID names real storage rather than RNONE.
   function automatic logic is_reg(input logic [3:0] id);
      return id != RNONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : reg_file_if                                                    |
// | Purpose   : Bundles the register-file read, write and debug signals.       |
// | Signals   : wr_en, stat_ok, srcA/srcB -> valA/valB, dstE/valE, dstM/valM,  |
// |             dbg_sel -> dbg_val, wr_count                                   |
// |             master = core/bench side, slave = register file                |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface reg_file_if #(
   parameter int DATA_W = 64
);
   logic              wr_en;
   logic              stat_ok;
   logic [3:0]        srcA;
   logic [3:0]        srcB;
   logic [DATA_W-1:0] valA;
   logic [DATA_W-1:0] valB;
   logic [3:0]        dstE;
   logic [DATA_W-1:0] valE;
   logic [3:0]        dstM;
   logic [DATA_W-1:0] valM;
   logic [3:0]        dbg_sel;
   logic [DATA_W-1:0] dbg_val;
   logic [31:0]       wr_count;

   modport master (
      output wr_en, stat_ok, srcA, srcB, dstE, valE, dstM, valM, dbg_sel,
      input  valA, valB, dbg_val, wr_count
   );

   modport slave (
      input  wr_en, stat_ok, srcA, srcB, dstE, valE, dstM, valM, dbg_sel,
      output valA, valB, dbg_val, wr_count
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_rdport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg_file_rdport                                                  |
// | Purpose : One register-file read port: ID-to-data mux, RNONE reads zero,   |
// |           optional forwarding of same-cycle write data.                    |
// | Ports   : sel (ID), regs (storage), fwd_en (commit this cycle),            |
// |           dstE/valE, dstM/valM (pending writes), val (read data)           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module reg_file_rdport
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter bit BYPASS = 1'b0
) (
   input  wire logic [3:0]                  sel,
   input  wire logic [14:0][DATA_W-1:0]     regs,
   input  wire logic                        fwd_en,
   input  wire logic [3:0]                  dstE,
   input  wire logic [DATA_W-1:0]           valE,
   input  wire logic [3:0]                  dstM,
   input  wire logic [DATA_W-1:0]           valM,
   output logic [DATA_W-1:0]                val
);

   always_comb begin
      val = '0;
      if (is_reg(sel)) begin
         val = regs[sel];
         // sel is a real ID here, so a match implies the dst is not RNONE.
         // M is checked first so a colliding pair forwards the winning value.
         if (BYPASS && fwd_en) begin
            if (sel == dstM) begin
               val = valM;
            end else if (sel == dstE) begin
               val = valE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg_file                                                         |
// | Purpose : Y86-64 SEQ architectural register file. Commits dstE/valE and    |
// |           dstM/valM on the clock edge, serves valA/valB to decode, plus a  |
// |           debug read port and a committed-write counter.                   |
// | Ports   : clk, rst (sync, active high), bus (reg_file_if.slave)            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module reg_file
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter logic [DATA_W-1:0] RSP_INIT = '0,
   parameter bit                BYPASS   = 1'b0
) (
   input  wire logic  clk,
   input  wire logic  rst,
   reg_file_if.slave  bus
);

   logic [14:0][DATA_W-1:0] r_regs;
   logic [31:0]             r_count;

   logic        w_commit;
   logic        w_we_e;
   logic        w_we_m;
   logic        w_coll;
   logic [31:0] w_inc;

   assign w_commit = bus.wr_en && bus.stat_ok;
   assign w_we_e   = w_commit && is_reg(bus.dstE);
   assign w_we_m   = w_commit && is_reg(bus.dstM);
   assign w_coll   = w_we_e && w_we_m && (bus.dstE == bus.dstM);

   // A colliding E/M pair lands in one register, so it counts once.
   always_comb begin
      w_inc = 32'd0;
      if (w_we_e && w_we_m && !w_coll) begin
         w_inc = 32'd2;
      end else if (w_we_e || w_we_m) begin
         w_inc = 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
         end
         r_count <= 32'd0;
      end else begin
         if (w_we_e) begin
            r_regs[bus.dstE] <= bus.valE;
         end
         // Issued after E so that M wins on a collision (popq %rsp).
         if (w_we_m) begin
            r_regs[bus.dstM] <= bus.valM;
         end
         r_count <= r_count + w_inc;
      end
   end

   assign bus.wr_count = r_count;

   reg_file_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rd_a (
      .sel    (bus.srcA),
      .regs   (r_regs),
      .fwd_en (w_commit),
      .dstE   (bus.dstE),
      .valE   (bus.valE),
      .dstM   (bus.dstM),
      .valM   (bus.valM),
      .val    (bus.valA)
   );

   reg_file_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rd_b (
      .sel    (bus.srcB),
      .regs   (r_regs),
      .fwd_en (w_commit),
      .dstE   (bus.dstE),
      .valE   (bus.valE),
      .dstM   (bus.dstM),
      .valM   (bus.valM),
      .val    (bus.valB)
   );

   // Debug port always shows stored state.
   reg_file_rdport #(.DATA_W(DATA_W), .BYPASS(1'b0)) u_rd_dbg (
      .sel    (bus.dbg_sel),
      .regs   (r_regs),
      .fwd_en (w_commit),
      .dstE   (bus.dstE),
      .valE   (bus.valE),
      .dstM   (bus.dstM),
      .valM   (bus.valM),
      .val    (bus.dbg_val)
   );

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_reg_file                                                      |
// | Purpose : Self-checking bench for reg_file. Drives a BYPASS=0 and a        |
// |           BYPASS=1 instance with identical stimulus and compares both      |
// |           against an array-based reference model.                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_reg_file;

   localparam int          DATA_W = 64;
   localparam logic [63:0] C_RSP  = 64'h200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_if #(.DATA_W(DATA_W)) bus0 ();
   reg_file_if #(.DATA_W(DATA_W)) bus1 ();

   reg_file #(.DATA_W(DATA_W), .RSP_INIT(C_RSP), .BYPASS(1'b0)) u_dut0 (
      .clk (clk), .rst (rst), .bus (bus0.slave)
   );
   reg_file #(.DATA_W(DATA_W), .RSP_INIT(C_RSP), .BYPASS(1'b1)) u_dut1 (
      .clk (clk), .rst (rst), .bus (bus1.slave)
   );

   // Reference model: architectural state as a plain array and counter.
   logic [63:0] model [15];
   logic [31:0] m_count;
   bit          m_valid;

   int n_cmp = 0;
   int n_err = 0;

   // Current cycle's inputs (mirrored to both buses).
   logic        c_rst, c_we, c_ok;
   logic [3:0]  c_srcA, c_srcB, c_dstE, c_dstM, c_dbg;
   logic [63:0] c_valE, c_valM;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_rd(input logic [3:0] id, input bit byp);
      if (id == 4'hF) return 64'd0;
      if (byp && c_we && c_ok) begin
         if (id == c_dstM) return c_valM;
         if (id == c_dstE) return c_valE;
      end
      return model[id];
   endfunction

   task automatic model_edge();
      int n;
      if (c_rst) begin
         for (int i = 0; i < 15; i++) model[i] = (i == 4) ? C_RSP : 64'd0;
         m_count = 32'd0;
         m_valid = 1'b1;
      end else if (c_we && c_ok) begin
         n = 0;
         if (c_dstE != 4'hF) begin model[c_dstE] = c_valE; n++; end
         if (c_dstM != 4'hF) begin
            model[c_dstM] = c_valM;
            if (c_dstM != c_dstE) n++;
         end
         m_count = m_count + 32'(n);
      end
   endtask

   // One clock: drive at negedge, check combinational outputs, take the edge.
   task automatic cycle(input logic r, input logic we, input logic ok,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] dbg);
      @(negedge clk);
      c_rst = r; c_we = we; c_ok = ok; c_srcA = sa; c_srcB = sb;
      c_dstE = de; c_valE = ve; c_dstM = dm; c_valM = vm; c_dbg = dbg;
      rst = r;
      bus0.wr_en = we; bus0.stat_ok = ok; bus0.srcA = sa; bus0.srcB = sb;
      bus0.dstE = de; bus0.valE = ve; bus0.dstM = dm; bus0.valM = vm; bus0.dbg_sel = dbg;
      bus1.wr_en = we; bus1.stat_ok = ok; bus1.srcA = sa; bus1.srcB = sb;
      bus1.dstE = de; bus1.valE = ve; bus1.dstM = dm; bus1.valM = vm; bus1.dbg_sel = dbg;
      #1;
      if (m_valid) begin
         check("valA_b0",  bus0.valA,    exp_rd(sa, 1'b0));
         check("valB_b0",  bus0.valB,    exp_rd(sb, 1'b0));
         check("dbg_b0",   bus0.dbg_val, exp_rd(dbg, 1'b0));
         check("count_b0", 64'(bus0.wr_count), 64'(m_count));
         check("valA_b1",  bus1.valA,    exp_rd(sa, 1'b1));
         check("valB_b1",  bus1.valB,    exp_rd(sb, 1'b1));
         check("dbg_b1",   bus1.dbg_val, exp_rd(dbg, 1'b0));
         check("count_b1", 64'(bus1.wr_count), 64'(m_count));
      end
      @(posedge clk);
      model_edge();
   endtask

   // Idle cycle that only reads.
   task automatic idle(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dbg);
      cycle(1'b0, 1'b0, 1'b1, sa, sb, 4'hF, 64'd0, 4'hF, 64'd0, dbg);
   endtask

   initial begin
      logic [3:0]  de, dm, sa, sb;
      m_valid = 1'b0;
      m_count = 32'd0;
      for (int i = 0; i < 15; i++) model[i] = 64'd0;

      // Reset, then sweep the debug port over every register.
      cycle(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF);
      for (int i = 0; i < 16; i++) idle(4'hF, 4'h4, 4'(i));

      // E write, visible the next cycle.
      cycle(1'b0, 1'b1, 1'b1, 4'h3, 4'hF, 4'h3, 64'h1234, 4'hF, 64'd0, 4'h3);
      idle(4'h3, 4'hF, 4'h3);

      // Dual write.
      cycle(1'b0, 1'b1, 1'b1, 4'h4, 4'h2, 4'h4, 64'h1F8, 4'h2, 64'hABCD, 4'h4);
      idle(4'h4, 4'h2, 4'h2);

      // Collision: M wins, one write counted.
      cycle(1'b0, 1'b1, 1'b1, 4'h4, 4'h4, 4'h4, 64'h208, 4'h4, 64'h55, 4'h4);
      idle(4'h4, 4'h4, 4'h4);

      // Suppression by stat_ok and by wr_en.
      cycle(1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 4'h1, 64'hFF, 4'hF, 64'd0, 4'h1);
      idle(4'hF, 4'h1, 4'h1);
      cycle(1'b0, 1'b0, 1'b1, 4'hF, 4'h1, 4'h1, 64'hFF, 4'h1, 64'hEE, 4'h1);
      idle(4'hF, 4'h1, 4'h1);

      // Same-cycle forwarding on instance 1.
      cycle(1'b0, 1'b1, 1'b1, 4'hF, 4'h6, 4'h6, 64'h77, 4'hF, 64'd0, 4'h6);
      idle(4'h6, 4'h6, 4'h6);

      // Reset beats a pending write.
      cycle(1'b0, 1'b1, 1'b1, 4'h6, 4'h6, 4'h6, 64'h99, 4'h7, 64'h88, 4'h6);
      cycle(1'b1, 1'b1, 1'b1, 4'h6, 4'h7, 4'h6, 64'h123, 4'h7, 64'h456, 4'h6);
      idle(4'h6, 4'h7, 4'h4);
      cycle(1'b0, 1'b1, 1'b1, 4'h6, 4'h7, 4'h6, 64'h5A, 4'hF, 64'd0, 4'h6);
      idle(4'h6, 4'h7, 4'h6);

      // Random traffic with collisions, RNONE, stalls and occasional reset.
      for (int k = 0; k < 600; k++) begin
         de = 4'($urandom_range(0, 15));
         dm = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) dm = de;
         sa = 4'($urandom_range(0, 15));
         sb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) sa = de;
         if ($urandom_range(0, 2) == 0) sb = dm;
         cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 7) != 0), sa, sb,
               de, {$urandom, $urandom}, dm, {$urandom, $urandom},
               4'($urandom_range(0, 15)));
      end
      idle(4'h0, 4'h1, 4'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
